// File: rtl/rem_serial_scheduler.sv
// rem_serial_scheduler
//   Shares one bit-serial remainder engine between N requesters. A
//   round-robin arbiter grants one requester in IDLE. Its word is then fed
//   MSB-first through the recurrence rem <- (2*rem + bit) mod d, one bit per
//   cycle. The result is returned with the owning requester's index on a
//   valid/ready port.
//
// Parameters
//   W  : word width (>= 2)
//   N  : number of requesters (>= 2)
//   IW : requester index width
//
// Ports
//   clk, rst             : clock, asynchronous active-high reset
//   req_valid [N]        : per-requester request valid
//   req_ready [N]        : per-requester grant (one-hot or zero, only in IDLE)
//   req_word  [N*W]      : requester i word at [i*W +: W]
//   req_div   [N*2]      : requester i divisor code at [i*2 +: 2] (3,4,5,7)
//   res_valid / res_ready: result handshake
//   res_rem   [3]        : remainder
//   res_id    [IW]       : index of the requester owning the result
//   busy                 : high whenever the engine is not idle
module rem_serial_scheduler #(
  parameter int W  = 8,
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [N*W-1:0]  req_word,
  input  logic [N*2-1:0]  req_div,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [2:0]      res_rem,
  output logic [IW-1:0]   res_id,
  output logic            busy
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [IW-1:0]   r_ptr, r_id;
  logic [W-1:0]    r_word;
  logic [2:0]      r_d, r_rem;
  logic [CW-1:0]   r_cnt;

  logic            w_gnt_any;
  logic [IW-1:0]   w_gnt_idx, w_ptr_next;
  logic [W-1:0]    w_sel_word;
  logic [1:0]      w_sel_div;
  logic            w_accept;

  function automatic logic [2:0] div_decode(input logic [1:0] code);
    case (code)
      2'd0:    return 3'd3;
      2'd1:    return 3'd4;
      2'd2:    return 3'd5;
      default: return 3'd7;
    endcase
  endfunction

  // rem < d on entry, so t < 2d and a single conditional subtract is exact.
  function automatic logic [2:0] rem_step(input logic [2:0] rem, input logic b,
                                          input logic [2:0] d);
    logic [3:0] t;
    t = {rem, b};
    if (t >= {1'b0, d}) return 3'(t - {1'b0, d});
    return t[2:0];
  endfunction

  // Round-robin search starting at r_ptr, wrapping modulo N.
  always_comb begin
    int j;
    j         = 0;
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < N; k++) begin
      j = (int'(r_ptr) + k) % N;
      if (!w_gnt_any && req_valid[IW'(j)]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = IW'(j);
      end
    end
  end

  always_comb begin
    w_sel_word = '0;
    w_sel_div  = '0;
    for (int k = 0; k < N; k++) begin
      if (IW'(k) == w_gnt_idx) begin
        w_sel_word = req_word[k*W +: W];
        w_sel_div  = req_div[k*2 +: 2];
      end
    end
  end

  assign w_ptr_next = (w_gnt_idx == IW'(N-1)) ? '0 : w_gnt_idx + 1'b1;
  assign w_accept   = |(req_valid & req_ready);

  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    res_valid = 1'b0;
    busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        // Grant is masked while rst is held so no request looks accepted.
        if (!rst && w_gnt_any) begin
          req_ready[w_gnt_idx] = 1'b1;
          w_next               = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cnt == CW'(W-1)) w_next = S_DONE;
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
      r_id  <= '0;
      r_rem <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_ptr <= w_ptr_next;
      r_id  <= w_gnt_idx;
      r_rem <= '0;
      r_cnt <= '0;
    end else if (r_state == S_SHIFT) begin
      r_rem <= rem_step(r_rem, r_word[W-1], r_d);
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // The word is shifted left so the bit being consumed is always the MSB.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_word <= w_sel_word;
      r_d    <= div_decode(w_sel_div);
    end else if (r_state == S_SHIFT) begin
      r_word <= r_word << 1;
    end
  end

  assign res_rem = r_rem;
  assign res_id  = r_id;

endmodule

// File: tb/tb_rem_serial_scheduler.sv
module tb_rem_serial_scheduler;

  localparam int W  = 8;
  localparam int N  = 2;
  localparam int IW = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_word;
  logic [N*2-1:0]  req_div;
  logic            res_valid;
  logic            res_ready;
  logic [2:0]      res_rem;
  logic [IW-1:0]   res_id;
  logic            busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rem_serial_scheduler #(.W(W), .N(N), .IW(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_word  (req_word),
    .req_div   (req_div),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_rem   (res_rem),
    .res_id    (res_id),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int dv(input logic [1:0] c);
    case (c)
      2'd0:    return 3;
      2'd1:    return 4;
      2'd2:    return 5;
      default: return 7;
    endcase
  endfunction

  task automatic set_req(input int id, input logic [7:0] word, input logic [1:0] code);
    req_word[id*W +: W] = word;
    req_div[id*2 +: 2]  = code;
  endtask

  // Called just after a negedge (+#1); returns with req_ready[id] seen or a failure logged.
  task automatic wait_grant(input int id, input string tag, output bit ok);
    int n;
    n = 0;
    while (!req_ready[id] && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    ok = req_ready[id];
    if (!ok) check({tag, "_grant_timeout"}, 0, 1);
  endtask

  task automatic wait_res(input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (res_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check({tag, "_res_timeout"}, 0, 1);
  endtask

  task automatic do_req(input int id, input logic [7:0] word, input logic [1:0] code,
                        input int exp, input string tag);
    int lat;
    bit ok;
    @(negedge clk);
    set_req(id, word, code);
    req_valid[id] = 1'b1;
    #1;
    wait_grant(id, tag, ok);
    if (!ok) begin
      req_valid[id] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[id] = 1'b0;
    lat = 0;
    while (!res_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, W);
    check({tag, "_rem"}, res_rem, exp);
    check({tag, "_id"}, res_id, id);
    @(negedge clk);
    check({tag, "_clr"}, res_valid, 0);
  endtask

  // Grant invariants hold on every cycle out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      check("rdy_onehot", 32'($onehot0(req_ready)), 1);
      check("rdy_idle_only", 32'(busy && (req_ready != '0)), 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected end");
    $fatal(1);
  end

  initial begin
    bit ok, saw;
    int e201[4] = '{0, 1, 1, 5};
    logic [7:0] cw[N];
    logic [1:0] cd[N];
    bit acc_prev[N];
    int q0[$];
    int q1[$];
    int issued, served, cyc;

    rst       = 1'b1;
    req_valid = '0;
    req_word  = '0;
    req_div   = '0;
    res_ready = 1'b1;

    // Both requesters valid from reset for the contention phase.
    set_req(0, 8'd201, 2'd3);
    set_req(1, 8'd77,  2'd2);
    req_valid = 2'b11;
    repeat (2) @(negedge clk);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_rem",   res_rem,   0);
    check("rst_res_id",    res_id,    0);
    check("rst_busy",      busy,      0);
    check("rst_req_ready", req_ready, 0);
    rst = 1'b0;
    #1;
    check("arb_first", req_ready, 2'b01);

    for (int t = 0; t < 4; t++) begin
      wait_res("cont", ok);
      check("cont_id",  res_id,  t % 2);
      check("cont_rem", res_rem, (t % 2 == 0) ? 5 : 2);
      if (t == 3) req_valid = '0;
      @(negedge clk);
    end

    for (int c = 0; c < 4; c++)
      do_req(0, 8'd201, 2'(c), e201[c], $sformatf("w201_d%0d", dv(2'(c))));

    do_req(0, 8'h00, 2'd3, 0, "edge_00_7");
    do_req(0, 8'hFF, 2'd0, 0, "edge_FF_3");
    do_req(0, 8'h80, 2'd3, 2, "edge_80_7");
    do_req(1, 8'hFF, 2'd2, 0, "edge_FF_5");
    do_req(0, 8'hFF, 2'd1, 3, "edge_FF_4");

    // Back-pressure: hold the result for 5 cycles with another request waiting.
    @(negedge clk);
    res_ready = 1'b0;
    set_req(1, 8'h80, 2'd3);
    req_valid[1] = 1'b1;
    #1;
    wait_grant(1, "bp", ok);
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    set_req(0, 8'd50, 2'd1);
    req_valid[0] = 1'b1;
    wait_res("bp", ok);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_valid", res_valid, 1);
      check("bp_rem",   res_rem,   2);
      check("bp_id",    res_id,    1);
      check("bp_busy",  busy,      1);
      check("bp_rdy",   req_ready, 0);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_rel_valid", res_valid, 0);
    check("bp_rel_busy",  busy,      0);
    check("bp_rel_grant", req_ready, 2'b01);
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("bp_next_busy", busy, 1);
    wait_res("bp_next", ok);
    check("bp_next_rem", res_rem, 2);
    check("bp_next_id",  res_id,  0);
    @(negedge clk);

    // Reset three cycles into SHIFT.
    set_req(0, 8'hFF, 2'd0);
    req_valid[0] = 1'b1;
    #1;
    wait_grant(0, "rmid", ok);
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rmid_busy",  busy,      0);
    check("rmid_valid", res_valid, 0);
    check("rmid_rem",   res_rem,   0);
    check("rmid_id",    res_id,    0);
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (res_valid) saw = 1'b1;
    end
    check("rmid_no_result", saw, 0);
    set_req(0, 8'd100, 2'd3);
    set_req(1, 8'd9,   2'd0);
    req_valid = 2'b11;
    #1;
    check("rmid_ptr0", req_ready, 2'b01);
    wait_res("rmid_a", ok);
    check("rmid_a_id",  res_id,  0);
    check("rmid_a_rem", res_rem, 2);
    req_valid[0] = 1'b0;
    @(negedge clk);
    wait_res("rmid_b", ok);
    check("rmid_b_id",  res_id,  1);
    check("rmid_b_rem", res_rem, 0);
    req_valid[1] = 1'b0;
    @(negedge clk);

    // Random soak against a per-requester FIFO of expected remainders.
    issued = 0;
    served = 0;
    cyc    = 0;
    for (int i = 0; i < N; i++) begin
      acc_prev[i] = 1'b0;
      cw[i] = '0;
      cd[i] = '0;
    end
    while ((issued < 1000 || served < issued) && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (acc_prev[i]) begin
          req_valid[i] = 1'b0;
          acc_prev[i]  = 1'b0;
        end
        if (!req_valid[i]) begin
          if (issued < 1000 && $urandom_range(0, 2) == 0) begin
            cw[i] = 8'($urandom);
            cd[i] = 2'($urandom);
            set_req(i, cw[i], cd[i]);
            req_valid[i] = 1'b1;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (res_valid && res_ready) begin
        served++;
        if (res_id == 0) begin
          if (q0.size() == 0) check("soak_extra0", 1, 0);
          else check("soak_rem0", res_rem, q0.pop_front());
        end else begin
          if (q1.size() == 0) check("soak_extra1", 1, 0);
          else check("soak_rem1", res_rem, q1.pop_front());
        end
      end
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          if (i == 0) q0.push_back(int'(cw[0]) % dv(cd[0]));
          else        q1.push_back(int'(cw[1]) % dv(cd[1]));
          issued++;
          acc_prev[i] = 1'b1;
        end
      end
    end
    req_valid = '0;
    res_ready = 1'b1;
    check("soak_issued",   32'(issued >= 1000), 1);
    check("soak_served",   served, issued);
    check("soak_pending",  q0.size() + q1.size(), 0);
    @(negedge clk);
    check("soak_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
